fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of the decode stage in the FDE CPU. It owns the program counter, issues reads to a synchronous instruction memory with fixed 1-cycle latency, and buffers returned 16-bit instructions in a small queue. It presents them to decode through a valid/ready handshake. It supports branch redirect/flush from execute and stops fetching on the HALT opcode.

Parameters:
ADDR_W, 8, PC / instruction-memory address width
DEPTH, 4, instruction queue entries (power of two, >= 2)
RESET_PC, 0, PC value loaded on reset

Ports:
i_clk  input  1  clock; all state updates on rising edge
i_rst_n  input  1  asynchronous active-low reset
i_start  input  1  one-cycle pulse; leaves IDLE and begins fetching at current PC
o_imem_req  output  1  memory read strobe this cycle
o_imem_addr  output  ADDR_W  read address (equals current PC when o_imem_req=1)
i_imem_rdata  input  16  read data, valid exactly one cycle after the request
o_valid  output  1  queue head holds a valid instruction
i_ready  input  1  decode accepts head this cycle
o_instruction  output  16  head instruction [15:12] opcode, [11:8] src1, [7:4] src2, [3:0] dest
o_pc  output  ADDR_W  address of head instruction
i_redirect  input  1  branch taken; flush and refetch
i_redirect_pc  input  ADDR_W  redirect target
o_halted  output  1  fetch stopped on HALT

Behaviour:
- Reset (async, i_rst_n=0): pc=RESET_PC, state=IDLE, queue empty, in-flight flag=0. Outputs o_valid=0, o_imem_req=0, o_halted=0. o_instruction and o_pc read 0 while empty.
- States: IDLE -> FETCH on i_start. FETCH -> HALT when an instruction with opcode 4'hF is written into the queue. HALT -> FETCH only on i_redirect. i_start is ignored outside IDLE.
- Issue rule, FETCH only: o_imem_req=1 when (count + inflight) < DEPTH, using registered values. Dequeues in the same cycle are not credited. On issue: o_imem_addr=pc, pc <= pc+1 modulo 2^ADDR_W (so 0xFF wraps to 0x00), inflight <= 1.
- Response: the cycle after an issue, {pc_of_request, i_imem_rdata} is enqueued unless that response was cancelled by a redirect.
- HALT instruction: it is enqueued and delivered to decode normally. No further requests are issued. A response that is already in flight when HALT is enqueued is dropped, and pc is rewound to HALT address+1. o_halted=1 in HALT.
- Handshake: o_valid = (count != 0). A transfer happens when o_valid && i_ready. o_instruction/o_pc are combinational from the head and stay stable while o_valid && !i_ready. Enqueue and dequeue in the same cycle leave count unchanged.
- Redirect (any state except IDLE): the queue is flushed to empty, the in-flight response is discarded, pc <= i_redirect_pc, and state goes to FETCH. It has priority over enqueue, dequeue, issue and HALT detection in that cycle. o_imem_req=0 during the redirect cycle, and the first request at the target issues the next cycle.
- Queue full: no issue, because the credit rule guarantees no overflow. Empty with i_ready=1: no-op.
- Reset asserted mid-operation returns to the reset state immediately. An in-flight response arriving after release is ignored.

Optional Feature:
FETCH_PERF_EN.
- Defined: adds 16-bit saturating counters o_perf_fetched and o_perf_stall, both reset to 0. o_perf_fetched increments on each decode transfer. o_perf_stall increments each cycle with o_valid=1 and i_ready=0. Both hold at 16'hFFFF.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package fetch_pkg: OPC_HALT=4'hF, the state encoding (IDLE, FETCH, HALT), and the instruction field index constants shared with decode.
- Sub-module fetch_queue: a synchronous DEPTH-entry FIFO with flush input, push/pop, count, and head outputs. fetch_unit instantiates it.

Test Plan:
- Streaming: memory holds 0x1234@0, 0x2345@1, 0x3456@2, i_ready=1, pulse i_start -> first o_valid the cycle after the first response. Outputs are (pc 0, 0x1234), (1, 0x2345), (2, 0x3456) on consecutive cycles. No duplicates or gaps.
- Backpressure: i_ready=0 for 10 cycles -> the queue fills to 4, o_imem_req stays 0, and the head stays pc 0 / 0x1234. On release, 4 instructions drain in order, then fetch resumes at pc 4.
- Redirect: with 3 queued entries and one in flight, assert i_redirect with target 0x40 -> the next cycle o_valid=0 and o_imem_req=0. Then a request issues at 0x40, and the next delivered instruction has o_pc=0x40.
- HALT: 0xF000 at pc 5 -> pc 5 is delivered and o_halted=1. No request for an address >5 appears. A subsequent redirect to 0x10 resumes fetch with o_halted=0.
- Wrap: RESET_PC=0xFE, i_start -> requests at 0xFE, 0xFF, 0x00, 0x01.
- Reset mid-stream: drop i_rst_n while o_valid=1 -> o_valid=0, o_halted=0 and o_imem_req=0 asynchronously, and the state is IDLE after release.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: HALT opcode, fetch FSM encoding, instruction field layout.
package fetch_pkg;

   localparam logic [3:0] OPC_HALT = 4'hF;
   localparam int         INSTR_W  = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HALT  = 2'd2
   } fetch_state_e;

   // Field layout seen by decode: [15:12] opcode, [11:8] src1, [7:4] src2, [3:0] dest.
   typedef struct packed {
      logic [3:0] opcode;
      logic [3:0] src1;
      logic [3:0] src2;
      logic [3:0] dest;
   } instr_t;

endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry instruction FIFO with synchronous flush; head reads zero while empty.
module fetch_queue #(
   parameter int DEPTH = 4,
   parameter int DW    = 24
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     push,
   input  logic [DW-1:0]            push_data,
   input  logic                     pop,
   output logic [$clog2(DEPTH):0]   count,
   output logic [DW-1:0]            head
);

   localparam int PW = $clog2(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (!push && pop) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= push_data;
   end

   assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues 1-cycle-latency reads, queues results for decode.
// Optional FETCH_PERF_EN adds saturating transfer/stall counters.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int                ADDR_W   = 8,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   output logic              o_imem_req,
   output logic [ADDR_W-1:0] o_imem_addr,
   input  logic [15:0]       i_imem_rdata,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [15:0]       o_instruction,
   output logic [ADDR_W-1:0] o_pc,
   input  logic              i_redirect,
   input  logic [ADDR_W-1:0] i_redirect_pc,
   output logic              o_halted
`ifdef FETCH_PERF_EN
   ,
   output logic [15:0]       o_perf_fetched,
   output logic [15:0]       o_perf_stall
`endif
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int DW = ADDR_W + INSTR_W;

   fetch_state_e      state, state_next;
   logic [ADDR_W-1:0] pc, pc_next, resp_pc;
   logic              inflight;
   logic [CW-1:0]     count;
   logic [DW-1:0]     head;
   logic              redir, push, pop, issue, resp_halt;
   instr_t            resp_instr;

   assign resp_instr = instr_t'(i_imem_rdata);
   assign redir      = i_redirect && (state != ST_IDLE);
   assign push       = inflight && !redir;
   assign resp_halt  = push && (resp_instr.opcode == OPC_HALT);
   assign o_valid    = (count != '0);
   assign pop        = o_valid && i_ready && !redir;

   // Credit uses registered occupancy only, so a same-cycle pop never opens a slot.
   assign issue = (state == ST_FETCH) && !redir && !resp_halt &&
                  ((count + CW'(inflight)) < CW'(DEPTH));

   always_comb begin
      state_next = state;
      pc_next    = pc;
      if (redir) begin
         state_next = ST_FETCH;
         pc_next    = i_redirect_pc;
      end else begin
         case (state)
            ST_IDLE:  if (i_start) state_next = ST_FETCH;
            ST_FETCH: if (resp_halt) state_next = ST_HALT;
            ST_HALT:  state_next = ST_HALT;
            default:  state_next = ST_IDLE;
         endcase
         if (resp_halt)  pc_next = resp_pc + 1'b1;
         else if (issue) pc_next = pc + 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state    <= ST_IDLE;
         pc       <= RESET_PC;
         inflight <= 1'b0;
         resp_pc  <= '0;
      end else begin
         state    <= state_next;
         pc       <= pc_next;
         inflight <= issue;
         if (issue) resp_pc <= pc;
      end
   end

   fetch_queue #(.DEPTH(DEPTH), .DW(DW)) u_queue (
      .clk       (i_clk),
      .rst_n     (i_rst_n),
      .flush     (redir),
      .push      (push),
      .push_data ({resp_pc, resp_instr}),
      .pop       (pop),
      .count     (count),
      .head      (head)
   );

   assign o_imem_req    = issue;
   assign o_imem_addr   = pc;
   assign o_instruction = head[INSTR_W-1:0];
   assign o_pc          = head[DW-1:INSTR_W];
   assign o_halted      = (state == ST_HALT);

`ifdef FETCH_PERF_EN
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_perf_fetched <= '0;
         o_perf_stall   <= '0;
      end else begin
         if (o_valid && i_ready && (o_perf_fetched != 16'hFFFF))
            o_perf_fetched <= o_perf_fetched + 16'd1;
         if (o_valid && !i_ready && (o_perf_stall != 16'hFFFF))
            o_perf_stall <= o_perf_stall + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based reference model checked every cycle, plus directed literal checks.
module tb_fetch_unit;

   localparam int DEPTH = 4;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b1;
   logic        i_start = 1'b0;
   logic        i_ready = 1'b0;
   logic        i_redirect = 1'b0;
   logic [7:0]  i_redirect_pc = 8'h00;
   logic [15:0] i_imem_rdata = 16'h0;
   logic        o_imem_req, o_valid, o_halted;
   logic [7:0]  o_imem_addr, o_pc;
   logic [15:0] o_instruction;

   logic        w_start = 1'b0;
   logic [15:0] w_rdata = 16'h0;
   logic        w_req, w_valid, w_halted;
   logic [7:0]  w_addr, w_pc;
   logic [15:0] w_instr;
`ifdef FETCH_PERF_EN
   logic [15:0] perf_f, perf_s, wperf_f, wperf_s;
`endif

   always #5 i_clk = ~i_clk;

   fetch_unit #(.ADDR_W(8), .DEPTH(DEPTH), .RESET_PC(8'h00)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
      .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .i_imem_rdata(i_imem_rdata),
      .o_valid(o_valid), .i_ready(i_ready), .o_instruction(o_instruction), .o_pc(o_pc),
      .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc), .o_halted(o_halted)
`ifdef FETCH_PERF_EN
      , .o_perf_fetched(perf_f), .o_perf_stall(perf_s)
`endif
   );

   fetch_unit #(.ADDR_W(8), .DEPTH(DEPTH), .RESET_PC(8'hFE)) dut_wrap (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(w_start),
      .o_imem_req(w_req), .o_imem_addr(w_addr), .i_imem_rdata(w_rdata),
      .o_valid(w_valid), .i_ready(1'b1), .o_instruction(w_instr), .o_pc(w_pc),
      .i_redirect(1'b0), .i_redirect_pc(8'h00), .o_halted(w_halted)
`ifdef FETCH_PERF_EN
      , .o_perf_fetched(wperf_f), .o_perf_stall(wperf_s)
`endif
   );

   logic [15:0] mem [256];

   always @(posedge i_clk) if (o_imem_req) i_imem_rdata <= mem[o_imem_addr];
   always @(posedge i_clk) if (w_req) w_rdata <= {8'h12, w_addr};

   int checks = 0;
   int passed = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   // Reference model: states 0=idle 1=fetch 2=halted; queue of {pc, instr}.
   int          m_state = 0;
   logic [7:0]  m_pc = 8'h00;
   logic [7:0]  m_ipc = 8'h00;
   bit          m_inf = 1'b0;
   logic [23:0] m_q[$];

   initial begin
      forever begin
         logic [23:0] hd;
         logic [15:0] rd;
         bit          redir, halt_now, req;
         @(negedge i_clk);
         if (!i_rst_n) begin
            m_state = 0; m_pc = 8'h00; m_inf = 1'b0; m_q.delete();
         end
         hd       = (m_q.size() != 0) ? m_q[0] : 24'h0;
         redir    = i_redirect && (m_state != 0);
         rd       = mem[m_ipc];
         halt_now = m_inf && !redir && (rd[15:12] == 4'hF);
         req      = (m_state == 1) && !redir && !halt_now && ((m_q.size() + int'(m_inf)) < DEPTH);
         chk("m_valid", o_valid, (m_q.size() != 0));
         chk("m_instr", o_instruction, hd[15:0]);
         chk("m_pc", o_pc, hd[23:16]);
         chk("m_req", o_imem_req, req);
         chk("m_halted", o_halted, (m_state == 2));
         if (req) chk("m_addr", o_imem_addr, m_pc);
         if (i_rst_n) begin
            if (redir) begin
               m_q.delete(); m_inf = 1'b0; m_pc = i_redirect_pc; m_state = 1;
            end else begin
               if (m_q.size() != 0 && i_ready) void'(m_q.pop_front());
               if (m_inf) m_q.push_back({m_ipc, rd});
               if (halt_now) begin
                  m_state = 2; m_pc = m_ipc + 8'd1; m_inf = 1'b0;
               end else if (req) begin
                  m_inf = 1'b1; m_ipc = m_pc; m_pc = m_pc + 8'd1;
               end else begin
                  m_inf = 1'b0;
               end
               if (m_state == 0 && i_start) m_state = 1;
            end
         end
      end
   end

   initial begin
      logic [15:0] w;
      logic [15:0] sexp [3];
      logic [7:0]  wexp [4];
      int n;
      sexp = '{16'h1234, 16'h2345, 16'h3456};
      wexp = '{8'hFE, 8'hFF, 8'h00, 8'h01};
      for (int i = 0; i < 256; i++) begin
         w = 16'($urandom);
         if (w[15:12] == 4'hF) w[15:12] = 4'hE;
         mem[i] = w;
      end
      mem[0] = 16'h1234; mem[1] = 16'h2345; mem[2] = 16'h3456;
      mem[5] = 16'hF000; mem[8'h23] = 16'hF123; mem[8'h77] = 16'hF077; mem[8'hC5] = 16'hF0C5;

      #1 i_rst_n = 1'b0;
      repeat (3) step();
      chk("rst_valid", o_valid, 0);
      chk("rst_req", o_imem_req, 0);
      chk("rst_halted", o_halted, 0);
      chk("rst_instr", o_instruction, 0);
      chk("rst_pc", o_pc, 0);
      i_rst_n = 1'b1;
      i_ready = 1'b1;
      step(); step();
      chk("idle_req", o_imem_req, 0);

      // PC wrap on the 0xFE-reset instance
      w_start = 1'b1;
      step();
      w_start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("wrap_req", w_req, 1);
         chk("wrap_addr", w_addr, wexp[k]);
         if (k == 2) begin
            chk("wrap_valid", w_valid, 1);
            chk("wrap_pc", w_pc, 8'hFE);
            chk("wrap_instr", w_instr, 16'h12FE);
            chk("wrap_halted", w_halted, 0);
         end
         step();
      end

      // streaming from pc 0
      i_start = 1'b1;
      step();
      i_start = 1'b0;
      chk("s_req", o_imem_req, 1);
      chk("s_addr", o_imem_addr, 0);
      chk("s_v0", o_valid, 0);
      step();
      chk("s_v1", o_valid, 0);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("s_valid", o_valid, 1);
         chk("s_pc", o_pc, k);
         chk("s_instr", o_instruction, sexp[k]);
      end

      // HALT at pc 5
      n = 0;
      while (!(o_valid && o_pc == 8'h05) && n < 30) begin step(); n++; end
      chk("h_pc", o_pc, 8'h05);
      chk("h_instr", o_instruction, 16'hF000);
      chk("h_halted", o_halted, 1);
      repeat (5) begin step(); chk("h_noreq", o_imem_req, 0); end

      // redirect out of HALT, then backpressure
      i_redirect = 1'b1; i_redirect_pc = 8'h10; i_ready = 1'b0;
      #1 chk("r_req", o_imem_req, 0);
      step();
      i_redirect = 1'b0;
      #1;
      chk("r_halted", o_halted, 0);
      chk("r_valid", o_valid, 0);
      chk("r_req2", o_imem_req, 1);
      chk("r_addr", o_imem_addr, 8'h10);
      repeat (10) step();
      chk("bp_req", o_imem_req, 0);
      chk("bp_valid", o_valid, 1);
      chk("bp_pc", o_pc, 8'h10);
      chk("bp_instr", o_instruction, mem[8'h10]);
      i_ready = 1'b1;
      #1;
      for (int k = 0; k < 5; k++) begin
         chk("bp_drain", o_pc, 8'h10 + k);
         step();
      end

      // redirect with a partly full queue and a request in flight
      i_ready = 1'b0;
      step(); step();
      i_redirect = 1'b1; i_redirect_pc = 8'h40; i_ready = 1'b1;
      #1 chk("rd_req0", o_imem_req, 0);
      step();
      i_redirect = 1'b0;
      #1;
      chk("rd_valid", o_valid, 0);
      chk("rd_req", o_imem_req, 1);
      chk("rd_addr", o_imem_addr, 8'h40);
      step(); step();
      chk("rd_hvalid", o_valid, 1);
      chk("rd_hpc", o_pc, 8'h40);

      // randomized traffic
      repeat (600) begin
         i_ready       = ($urandom_range(0, 3) != 0);
         i_redirect    = ($urandom_range(0, o_halted ? 3 : 20) == 0);
         i_redirect_pc = 8'($urandom);
         step();
      end

      // reset while the queue holds data
      i_redirect = 1'b1; i_redirect_pc = 8'h30; i_ready = 1'b0;
      step();
      i_redirect = 1'b0;
      n = 0;
      while (!o_valid && n < 20) begin step(); n++; end
      chk("mr_pre", o_valid, 1);
      @(posedge i_clk);
      #3 i_rst_n = 1'b0;
      #1;
      chk("mr_valid", o_valid, 0);
      chk("mr_halted", o_halted, 0);
      chk("mr_req", o_imem_req, 0);
      step(); step();
      i_rst_n = 1'b1;
      step(); step();
      chk("mr_idle_req", o_imem_req, 0);
      chk("mr_idle_valid", o_valid, 0);

      i_start = 1'b1;
      step();
      i_start = 1'b0;
      repeat (40) begin
         i_ready    = ($urandom_range(0, 1) != 0);
         i_redirect = ($urandom_range(0, 10) == 0);
         i_redirect_pc = 8'($urandom);
         step();
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
